// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller for the 5-stage MIPS pipeline.
//
// Takes the EX/MEM pipeline register outputs and, for loads and stores, runs a
// variable-latency req/ack handshake with the data memory. The rest of the
// pipeline is held while an access is outstanding. A stuck access is aborted
// after a bounded number of cycles. The block also registers the MEM/WB fields
// used by write-back and forwarding.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   MemReadM, MemWriteM         load / store in MEM
//   MemtoRegM, RegWriteM        write-back controls from EX/MEM
//   ALUResultM, ReadDataM       address or ALU result, store data
//   RegisterDstM                destination register
//   dmem_req/we/addr/wdata      registered data-memory request
//   dmem_ack, dmem_rdata        memory completion and load data (same cycle)
//   StallM                      combinational hold for PC/IF/ID/EX/EX-MEM
//   RegWriteW, MemtoRegW,
//   ALUResultW, MemDataW,
//   RegisterDstW                MEM/WB pipeline register
//   AlignErr, BusErr            one-cycle pulses: misaligned drop, timeout abort
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic        RegWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] ReadDataM,
    input  logic [4:0]  RegisterDstM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ALUResultW,
    output logic [31:0] MemDataW,
    output logic [4:0]  RegisterDstW,
    output logic        AlignErr,
    output logic        BusErr
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            regwrite_q, regwrite_d;
    logic            memtoreg_q, memtoreg_d;
    logic [31:0]     aluresult_q, aluresult_d;
    logic [31:0]     memdata_q, memdata_d;
    logic [4:0]      dst_q, dst_d;
    logic            align_err_q, align_err_d;
    logic            bus_err_q, bus_err_d;
    logic            stall;

    logic memop;
    logic bad;
    logic is_load;

    assign memop   = MemReadM | MemWriteM;
    assign bad     = (ALIGN_CHECK != 0) && memop && (ALUResultM[1:0] != 2'b00);
    // Read+write together behaves as a store, so it never returns load data.
    assign is_load = MemReadM & ~MemWriteM;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        // MEM/WB defaults to a bubble; only completed instructions overwrite it.
        regwrite_d  = 1'b0;
        memtoreg_d  = 1'b0;
        aluresult_d = '0;
        memdata_d   = '0;
        dst_d       = '0;
        align_err_d = 1'b0;
        bus_err_d   = 1'b0;
        stall       = 1'b0;

        case (state_q)
            StIdle: begin
                if (!memop) begin
                    regwrite_d  = RegWriteM;
                    memtoreg_d  = MemtoRegM;
                    aluresult_d = ALUResultM;
                    dst_d       = RegisterDstM;
                end else if (bad) begin
                    align_err_d = 1'b1;
                end else begin
                    stall   = 1'b1;
                    req_d   = 1'b1;
                    we_d    = MemWriteM;
                    addr_d  = ALUResultM;
                    wdata_d = ReadDataM;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (dmem_ack) begin
                    regwrite_d  = RegWriteM;
                    memtoreg_d  = MemtoRegM;
                    aluresult_d = ALUResultM;
                    dst_d       = RegisterDstM;
                    memdata_d   = is_load ? dmem_rdata : 32'h0;
                    req_d       = 1'b0;
                    state_d     = StIdle;
                end else if (cnt_q == CntLast) begin
                    // Release the pipeline in the last cycle; the dropped
                    // instruction leaves a bubble and a BusErr pulse.
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            aluresult_q <= '0;
            memdata_q   <= '0;
            dst_q       <= '0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            aluresult_q <= aluresult_d;
            memdata_q   <= memdata_d;
            dst_q       <= dst_d;
            align_err_q <= align_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign StallM       = stall;
    assign RegWriteW    = regwrite_q;
    assign MemtoRegW    = memtoreg_q;
    assign ALUResultW   = aluresult_q;
    assign MemDataW     = memdata_q;
    assign RegisterDstW = dst_q;
    assign AlignErr     = align_err_q;
    assign BusErr       = bus_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed self-checking bench for mem_stage_ctrl.
// Inputs change and outputs are sampled on the falling clock edge; the DUT
// acts on the rising edge. Expected MEM/WB contents are queued when an
// instruction is issued and popped when it reaches write-back.
module tb_mem_stage_ctrl;

    localparam int unsigned TIMEOUT = 4;

    logic        clk;
    logic        reset;
    logic        MemReadM, MemWriteM, MemtoRegM, RegWriteM;
    logic [31:0] ALUResultM, ReadDataM;
    logic [4:0]  RegisterDstM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic        RegWriteW, MemtoRegW;
    logic [31:0] ALUResultW, MemDataW;
    logic [4:0]  RegisterDstW;
    logic        AlignErr, BusErr;

    mem_stage_ctrl #(
        .TIMEOUT     (TIMEOUT),
        .ALIGN_CHECK (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemReadM     (MemReadM),
        .MemWriteM    (MemWriteM),
        .MemtoRegM    (MemtoRegM),
        .RegWriteM    (RegWriteM),
        .ALUResultM   (ALUResultM),
        .ReadDataM    (ReadDataM),
        .RegisterDstM (RegisterDstM),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .StallM       (StallM),
        .RegWriteW    (RegWriteW),
        .MemtoRegW    (MemtoRegW),
        .ALUResultW   (ALUResultW),
        .MemDataW     (MemDataW),
        .RegisterDstW (RegisterDstW),
        .AlignErr     (AlignErr),
        .BusErr       (BusErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        mtr;
        logic [31:0] alu;
        logic [31:0] data;
        logic [4:0]  dst;
        logic        bubble;
    } wb_t;

    wb_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic mtr, input logic rw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst);
        MemReadM     = rd;
        MemWriteM    = wr;
        MemtoRegM    = mtr;
        RegWriteM    = rw;
        ALUResultM   = alu;
        ReadDataM    = wd;
        RegisterDstM = dst;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic push_exp(input logic rw, input logic mtr, input logic [31:0] alu,
                            input logic [31:0] data, input logic [4:0] dst, input logic bubble);
        wb_t e;
        e.rw = rw; e.mtr = mtr; e.alu = alu; e.data = data; e.dst = dst; e.bubble = bubble;
        exp_q.push_back(e);
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk1({tag, "_rw"}, RegWriteW, e.rw);
            chk1({tag, "_mtr"}, MemtoRegW, e.mtr);
            if (!e.bubble) begin
                chk32({tag, "_alu"}, ALUResultW, e.alu);
                chk32({tag, "_data"}, MemDataW, e.data);
                chk32({tag, "_dst"}, 32'(RegisterDstW), 32'(e.dst));
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        nop();
        @(negedge clk);
        @(negedge clk);
        chk1("rst_req", dmem_req, 1'b0);
        chk1("rst_rw", RegWriteW, 1'b0);
        chk1("rst_stall", StallM, 1'b0);
        chk1("rst_aerr", AlignErr, 1'b0);
        chk1("rst_berr", BusErr, 1'b0);
        chk32("rst_alu", ALUResultW, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // ALU op passes straight through in one cycle
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd5);
        #1 chk1("alu_stall", StallM, 1'b0);
        push_exp(1'b1, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b0);
        @(negedge clk);
        check_wb("alu");

        // Load 0x100, ack in the third BUSY cycle
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd7);
        #1 chk1("ld_stall0", StallM, 1'b1);
        chk1("ld_req0", dmem_req, 1'b0);
        @(negedge clk);
        chk1("ld_req1", dmem_req, 1'b1);
        chk1("ld_we", dmem_we, 1'b0);
        chk32("ld_addr", dmem_addr, 32'h100);
        chk1("ld_bubble1", RegWriteW, 1'b0);
        chk1("ld_stall1", StallM, 1'b1);
        @(negedge clk);
        chk1("ld_req2", dmem_req, 1'b1);
        chk1("ld_stall2", StallM, 1'b1);
        @(negedge clk);
        chk1("ld_req3", dmem_req, 1'b1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1 chk1("ld_stall3", StallM, 1'b0);
        push_exp(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 5'd7, 1'b0);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk1("ld_req4", dmem_req, 1'b0);
        check_wb("ld");
        nop();
        @(negedge clk);
        chk1("ld_rw_once", RegWriteW, 1'b0);

        // Store 0x200 with immediate ack
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'hA5A5A5A5, 5'd0);
        #1 chk1("st_stall0", StallM, 1'b1);
        @(negedge clk);
        chk1("st_req", dmem_req, 1'b1);
        chk1("st_we", dmem_we, 1'b1);
        chk32("st_addr", dmem_addr, 32'h200);
        chk32("st_wdata", dmem_wdata, 32'hA5A5A5A5);
        dmem_ack = 1'b1;
        #1 chk1("st_stall1", StallM, 1'b0);
        push_exp(1'b0, 1'b0, 32'h200, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk1("st_req_end", dmem_req, 1'b0);
        check_wb("st");

        // Misaligned load is dropped
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd9);
        #1 chk1("al_stall", StallM, 1'b0);
        push_exp(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1);
        @(negedge clk);
        chk1("al_err", AlignErr, 1'b1);
        chk1("al_req", dmem_req, 1'b0);
        check_wb("al");
        nop();
        @(negedge clk);
        chk1("al_err_pulse", AlignErr, 1'b0);
        chk1("al_req_after", dmem_req, 1'b0);

        // Timeout: no ack for TIMEOUT BUSY cycles
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd3);
        #1 chk1("to_stall0", StallM, 1'b1);
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            @(negedge clk);
            chk1($sformatf("to_req%0d", i), dmem_req, 1'b1);
            chk1($sformatf("to_berr%0d", i), BusErr, 1'b0);
            chk1($sformatf("to_rw%0d", i), RegWriteW, 1'b0);
            #1 chk1($sformatf("to_stall_busy%0d", i), StallM, i < int'(TIMEOUT) - 1);
        end
        @(negedge clk);
        chk1("to_berr", BusErr, 1'b1);
        chk1("to_req_drop", dmem_req, 1'b0);
        chk1("to_rw_bubble", RegWriteW, 1'b0);
        // Back-to-back load right after the abort
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'h0, 5'd4);
        #1 chk1("b2b_stall0", StallM, 1'b1);
        @(negedge clk);
        chk1("to_berr_pulse", BusErr, 1'b0);
        chk1("b2b_req", dmem_req, 1'b1);
        chk32("b2b_addr", dmem_addr, 32'h104);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h000055AA;
        #1 chk1("b2b_stall1", StallM, 1'b0);
        push_exp(1'b1, 1'b1, 32'h104, 32'h000055AA, 5'd4, 1'b0);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk1("b2b_req_end", dmem_req, 1'b0);
        check_wb("b2b");

        // Mid-transaction asynchronous reset
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd6);
        @(negedge clk);
        chk1("mr_req_pre", dmem_req, 1'b1);
        chk32("mr_addr_pre", dmem_addr, 32'h400);
        #2 reset = 1'b1;
        nop();
        #1;
        chk1("mr_req", dmem_req, 1'b0);
        chk32("mr_addr", dmem_addr, 32'h0);
        chk1("mr_rw", RegWriteW, 1'b0);
        chk1("mr_stall", StallM, 1'b0);
        chk1("mr_berr", BusErr, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        // Back in IDLE: a stray ack is ignored and an ALU op passes through
        dmem_ack = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBEEF, 32'h0, 5'd10);
        #1 chk1("pr_stall", StallM, 1'b0);
        push_exp(1'b1, 1'b0, 32'hBEEF, 32'h0, 5'd10, 1'b0);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk1("pr_req", dmem_req, 1'b0);
        check_wb("pr");
        nop();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
